// File: rtl/alb_rr_sequencer.sv
// Two-requester round-robin sequencer that shares one external combinational ALB.
// Operands are registered onto the ALB, and the result is captured one cycle later and returned per requester.
module alb_rr_sequencer #(
  parameter int DW      = 8,
  parameter int CNT_W   = 16,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DW-1:0]    req0_r,
  input  logic [DW-1:0]    req0_s,
  input  logic             req0_ci,
  input  logic [1:0]       req0_mi,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DW-1:0]    req1_r,
  input  logic [DW-1:0]    req1_s,
  input  logic             req1_ci,
  input  logic [1:0]       req1_mi,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [DW-1:0]    rsp_f,
  output logic [3:0]       rsp_flags,
  output logic [DW-1:0]    alb_r,
  output logic [DW-1:0]    alb_s,
  output logic             alb_ci,
  output logic [1:0]       alb_mi,
  input  logic [DW-1:0]    alb_f,
  input  logic             alb_co,
  input  logic             alb_zo,
  input  logic             alb_no,
  input  logic             alb_vo,
  output logic             grant_id,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t  state_r;
  state_t  state_s;
  logic    last_grant_r;
  logic    win_s;
  logic    accept_s;
  logic    rsp_hs_s;

  // Arbitration, ready generation and next-state selection.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    // A tie goes to the requester that did not win last time.
    if (req0_valid && req1_valid) begin
      win_s = ~last_grant_r;
    end else if (req1_valid) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    rsp_hs_s = grant_id ? rsp1_ready : rsp0_ready;
    case (state_r)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          accept_s   = 1'b1;
          req0_ready = ~win_s;
          req1_ready = win_s;
          state_s    = EXEC;
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: state_s = RESP;
      RESP: begin
        if (rsp_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, operand, result and counter registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_r      <= IDLE;
      last_grant_r <= ~RR_INIT;
      grant_id     <= 1'b0;
      busy         <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      alb_r        <= {DW{1'b0}};
      alb_s        <= {DW{1'b0}};
      alb_ci       <= 1'b0;
      alb_mi       <= 2'b00;
      rsp_f        <= {DW{1'b0}};
      rsp_flags    <= 4'b0000;
      ops_done     <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_s;
      busy       <= (state_s != IDLE);
      // grant_id is already settled by the time RESP can be entered.
      rsp0_valid <= (state_s == RESP) && !grant_id;
      rsp1_valid <= (state_s == RESP) && grant_id;
      if (accept_s) begin
        alb_r        <= win_s ? req1_r  : req0_r;
        alb_s        <= win_s ? req1_s  : req0_s;
        alb_ci       <= win_s ? req1_ci : req0_ci;
        alb_mi       <= win_s ? req1_mi : req0_mi;
        grant_id     <= win_s;
        last_grant_r <= win_s;
      end
      if (state_r == EXEC) begin
        rsp_f     <= alb_f;
        rsp_flags <= {alb_co, alb_zo, alb_no, alb_vo};
      end
      if ((state_r == RESP) && rsp_hs_s) begin
        ops_done <= ops_done + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alb_rr_sequencer.sv
// Self-checking bench for alb_rr_sequencer: behavioural ALB stub plus a transaction-level
// arbitration/counter model, directed scenarios and randomized traffic.
module tb_alb_rr_sequencer;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_r = '0, req0_s = '0, req1_r = '0, req1_s = '0;
  logic          req0_ci = 1'b0, req1_ci = 1'b0;
  logic [1:0]    req0_mi = 2'b00, req1_mi = 2'b00;
  logic          rsp0_valid, rsp1_valid;
  logic          rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [DW-1:0] rsp_f, alb_r, alb_s, alb_f;
  logic [3:0]    rsp_flags;
  logic          alb_ci, alb_co, alb_zo, alb_no, alb_vo;
  logic [1:0]    alb_mi;
  logic          grant_id, busy;
  logic [CW-1:0] ops_done;

  int checks = 0;
  int errors = 0;
  bit m_last;
  int m_ops;

  always #5 clk = ~clk;

  // Reference ALU: returns {CO,ZO,NO,VO,F} using plain integer arithmetic.
  function automatic logic [11:0] alb_calc(input logic [7:0] r, input logic [7:0] s,
                                           input logic ci, input logic [1:0] mi);
    int sum;
    logic [7:0] f;
    logic co, vo;
    co = 1'b0; vo = 1'b0; sum = 0;
    case (mi)
      2'b00: f = r | s;
      2'b01: begin
        sum = int'(r) + int'(s) + int'(ci);
        f = sum[7:0]; co = (sum > 255);
        vo = (r[7] == s[7]) && (f[7] != r[7]);
      end
      2'b10: begin
        sum = int'(s) + (255 - int'(r)) + int'(ci);
        f = sum[7:0]; co = (sum > 255);
        vo = (s[7] != r[7]) && (f[7] != s[7]);
      end
      default: f = r ^ s;
    endcase
    return {co, (f == 8'h00), f[7], vo, f};
  endfunction

  assign {alb_co, alb_zo, alb_no, alb_vo, alb_f} = alb_calc(alb_r, alb_s, alb_ci, alb_mi);

  alb_rr_sequencer #(.DW(DW), .CNT_W(CW), .RR_INIT(1'b0)) dut (
    .clk(clk), .resetb(resetb),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r(req0_r), .req0_s(req0_s),
    .req0_ci(req0_ci), .req0_mi(req0_mi),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r(req1_r), .req1_s(req1_s),
    .req1_ci(req1_ci), .req1_mi(req1_mi),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_f(rsp_f), .rsp_flags(rsp_flags),
    .alb_r(alb_r), .alb_s(alb_s), .alb_ci(alb_ci), .alb_mi(alb_mi),
    .alb_f(alb_f), .alb_co(alb_co), .alb_zo(alb_zo), .alb_no(alb_no), .alb_vo(alb_vo),
    .grant_id(grant_id), .busy(busy), .ops_done(ops_done)
  );

  task automatic apply_reset();
    resetb = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    m_last = 1'b1;
    m_ops = 0;
    @(posedge clk); #1;
  endtask

  // One complete transaction from IDLE; called at posedge+1 with requests already driven.
  task automatic do_op(input int stall, input bit hold1,
                       output logic [7:0] f_o, output logic [3:0] fl_o, output bit w_o);
    bit w;
    logic [7:0] er, es;
    logic ci;
    logic [1:0] mi;
    logic [11:0] exp_v;
    if (req0_valid && req1_valid) w = ~m_last;
    else w = req1_valid;
    er = w ? req1_r : req0_r;  es = w ? req1_s : req0_s;
    ci = w ? req1_ci : req0_ci; mi = w ? req1_mi : req0_mi;
    exp_v = alb_calc(er, es, ci, mi);
    #1;
    checks++;
    if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01))
      $display("FAIL ready: got %b want %b", {req1_ready, req0_ready}, (w ? 2'b10 : 2'b01));
    if ({req1_ready, req0_ready} !== (w ? 2'b10 : 2'b01)) errors++;
    @(posedge clk); #1;
    m_last = w;
    if (!w) req0_valid = 1'b0;
    else if (!hold1) req1_valid = 1'b0;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, grant_id} !== {1'b1, 1'b0, 1'b0, w}) begin
      errors++;
      $display("FAIL exec_state: got %b want %b", {busy, rsp0_valid, rsp1_valid, grant_id}, {1'b1, 1'b0, 1'b0, w});
    end
    checks++;
    if ({alb_r, alb_s, alb_ci, alb_mi} !== {er, es, ci, mi}) begin
      errors++;
      $display("FAIL alb_operands: got %h want %h", {alb_r, alb_s, alb_ci, alb_mi}, {er, es, ci, mi});
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp1_valid, rsp0_valid} !== (w ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL rsp_valid: got %b want %b", {rsp1_valid, rsp0_valid}, (w ? 2'b10 : 2'b01));
    end
    checks++;
    if ({rsp_flags, rsp_f} !== exp_v) begin
      errors++;
      $display("FAIL rsp_data: got %h want %h", {rsp_flags, rsp_f}, exp_v);
    end
    f_o = rsp_f; fl_o = rsp_flags; w_o = w;
    if (w) rsp0_ready = 1'b1;
    else rsp1_ready = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_flags, rsp_f, alb_r, alb_s, ops_done}
          !== {(w ? 2'b10 : 2'b01), 2'b00, exp_v, er, es, CW'(m_ops)}) begin
        errors++;
        $display("FAIL stall_hold: got %h want %h",
                 {rsp1_valid, rsp0_valid, req1_ready, req0_ready, rsp_flags, rsp_f, alb_r, alb_s, ops_done},
                 {(w ? 2'b10 : 2'b01), 2'b00, exp_v, er, es, CW'(m_ops)});
      end
    end
    if (w) rsp1_ready = 1'b1;
    else rsp0_ready = 1'b1;
    @(posedge clk); #1;
    m_ops++;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    checks++;
    if ({busy, rsp0_valid, rsp1_valid, ops_done} !== {1'b0, 1'b0, 1'b0, CW'(m_ops)}) begin
      errors++;
      $display("FAIL done: got %h want %h", {busy, rsp0_valid, rsp1_valid, ops_done}, {1'b0, 1'b0, 1'b0, CW'(m_ops)});
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    #3;
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_f, rsp_flags, alb_r, alb_s,
         alb_ci, alb_mi, grant_id, busy, ops_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_f, rsp_flags, alb_r, alb_s, alb_ci, alb_mi, grant_id, busy, ops_done});
    end
    apply_reset();
  endtask

  task automatic test_tie();
    logic [7:0] f; logic [3:0] fl; bit w;
    req0_r = 8'h01; req0_s = 8'h02; req0_ci = 1'b1; req0_mi = 2'b01;
    req1_r = 8'h05; req1_s = 8'h07; req1_ci = 1'b1; req1_mi = 2'b10;
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(0, 1'b0, f, fl, w);
    checks++;
    if ({w, f} !== {1'b0, 8'h04}) begin
      errors++; $display("FAIL tie_first: got %h want %h", {w, f}, {1'b0, 8'h04});
    end
    do_op(0, 1'b0, f, fl, w);
    checks++;
    if ({w, f, fl} !== {1'b1, 8'h02, 4'b1000}) begin
      errors++; $display("FAIL tie_second: got %h want %h", {w, f, fl}, {1'b1, 8'h02, 4'b1000});
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    do_op(0, 1'b0, f, fl, w);
    checks++;
    if (w !== 1'b0) begin
      errors++; $display("FAIL tie_third: got %b want 0", w);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] f; logic [3:0] fl; bit w;
    req0_r = 8'h0F; req0_s = 8'hF0; req0_ci = 1'b0; req0_mi = 2'b00; req0_valid = 1'b1;
    do_op(0, 1'b0, f, fl, w);
    checks++;
    if ({w, f, fl[2]} !== {1'b0, 8'hFF, 1'b0}) begin
      errors++; $display("FAIL single_or: got %h want %h", {w, f, fl[2]}, {1'b0, 8'hFF, 1'b0});
    end
  endtask

  task automatic test_stall();
    logic [7:0] f; logic [3:0] fl; bit w;
    req0_r = 8'h80; req0_s = 8'h80; req0_ci = 1'b0; req0_mi = 2'b01; req0_valid = 1'b1;
    req1_r = 8'h33; req1_s = 8'h55; req1_ci = 1'b0; req1_mi = 2'b11; req1_valid = 1'b1;
    do_op(5, 1'b0, f, fl, w);
    do_op(2, 1'b0, f, fl, w);
  endtask

  task automatic test_reset_mid();
    logic [7:0] f; logic [3:0] fl; bit w;
    req1_r = 8'h12; req1_s = 8'h34; req1_ci = 1'b1; req1_mi = 2'b01; req1_valid = 1'b1;
    @(posedge clk); #3;
    resetb = 1'b0; req1_valid = 1'b0;
    #1;
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp_f, rsp_flags, alb_r, alb_s, alb_ci, alb_mi, grant_id, busy, ops_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h want 0", {rsp0_valid, rsp1_valid, rsp_f, rsp_flags, alb_r, alb_s,
               alb_ci, alb_mi, grant_id, busy, ops_done});
    end
    apply_reset();
    checks++;
    if ({rsp0_valid, rsp1_valid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_no_rsp: got %b want 000", {rsp0_valid, rsp1_valid, busy});
    end
    req1_r = 8'hAA; req1_s = 8'hAA; req1_ci = 1'b0; req1_mi = 2'b11; req1_valid = 1'b1;
    do_op(1, 1'b0, f, fl, w);
    checks++;
    if ({w, f, fl[2]} !== {1'b1, 8'h00, 1'b1}) begin
      errors++; $display("FAIL xor_zero: got %h want %h", {w, f, fl[2]}, {1'b1, 8'h00, 1'b1});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] f; logic [3:0] fl; bit w;
    apply_reset();
    req1_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      req1_r = 8'($urandom); req1_s = 8'($urandom); req1_ci = 1'($urandom); req1_mi = 2'($urandom);
      do_op(0, 1'b1, f, fl, w);
    end
    req1_valid = 1'b0;
    checks++;
    if ({ops_done, grant_id} !== {4'd0, 1'b1}) begin
      errors++; $display("FAIL wrap: got %h want %h", {ops_done, grant_id}, {4'd0, 1'b1});
    end
  endtask

  task automatic test_alternate();
    logic [7:0] f; logic [3:0] fl; bit w;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req0_r = 8'($urandom); req0_s = 8'($urandom); req0_mi = 2'($urandom); req0_valid = 1'b1;
      do_op(0, 1'b1, f, fl, w);
      checks++;
      if (w !== 1'(i % 2)) begin
        errors++; $display("FAIL alternate[%0d]: got %b want %b", i, w, 1'(i % 2));
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] f; logic [3:0] fl; bit w;
    logic [1:0] v;
    for (int i = 0; i < 40; i++) begin
      v = 2'($urandom_range(1, 3));
      if (v[0] && !req0_valid) begin
        req0_r = 8'($urandom); req0_s = 8'($urandom); req0_ci = 1'($urandom); req0_mi = 2'($urandom);
        req0_valid = 1'b1;
      end
      if (v[1] && !req1_valid) begin
        req1_r = 8'($urandom); req1_s = 8'($urandom); req1_ci = 1'($urandom); req1_mi = 2'($urandom);
        req1_valid = 1'b1;
      end
      do_op($urandom_range(0, 3), 1'b0, f, fl, w);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_alternate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
